// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sizing helpers for CPU datapath units.
// Count-result widths are derived here so every unit agrees.
package cpu_pkg;

  // Bits needed to hold a count in 0..w inclusive.
  function automatic int popcnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/num_ones_tree.sv
// num_ones_tree: combinational adder tree counting set bits of A.
// Pairs are summed level by level; an odd leftover is passed up.
module num_ones_tree
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = popcnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] A,
  output logic [OUT_W-1:0] sum
);

  localparam int LEVELS = $clog2(WIDTH);

  // Reduce the bit vector level by level down to a single node.
  always_comb begin : tree
    logic [OUT_W-1:0] lvl [LEVELS+1][WIDTH+1];
    int n;
    for (int l = 0; l <= LEVELS; l++) begin
      for (int i = 0; i <= WIDTH; i++) begin
        lvl[l][i] = '0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      lvl[0][i] = OUT_W'(A[i]);
    end
    n = WIDTH;
    for (int l = 1; l <= LEVELS; l++) begin
      for (int i = 0; i < (WIDTH + 1) / 2; i++) begin
        if (2 * i + 1 < n) begin
          lvl[l][i] = lvl[l-1][2*i]
                    + lvl[l-1][2*i+1];
        end else if (2 * i < n) begin
          lvl[l][i] = lvl[l-1][2*i];
        end
      end
      n = (n + 1) / 2;
    end
    sum = lvl[LEVELS][0];
  end

endmodule

// File: rtl/num_ones_unit.sv
// num_ones_unit: registered population count with valid flag.
// One cycle latency, one word per cycle, no backpressure.
module num_ones_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_W = popcnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  output logic [OUT_W-1:0] ones,
  output logic             out_valid
);

  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] ones_d;
  logic [OUT_W-1:0] ones_q;
  logic             out_valid_d;
  logic             out_valid_q;

  num_ones_tree #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_tree (
    .A   (A),
    .sum (sum)
  );

  // Load a new count only on valid input; otherwise hold it.
  always_comb begin
    ones_d      = ones_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      ones_d      = sum;
      out_valid_d = 1'b1;
    end
  end

  // Output register stage; reset wins over a valid input.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ones      = ones_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_num_ones_unit.sv
// tb_num_ones_unit: directed table plus random width sweep.
// Expected counts come from a bit-summing reference model.
module tb_num_ones_unit;

  logic clk = 1'b0;
  logic reset;
  logic v16;
  logic [15:0] a16;
  logic [4:0] ones16;
  logic ov16;

  logic vs;
  logic [0:0] a1;
  logic [4:0] a5;
  logic [31:0] a32;
  logic [0:0] ones1;
  logic [2:0] ones5;
  logic [5:0] ones32;
  logic ov1, ov5, ov32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  num_ones_unit #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(v16),
    .A(a16), .ones(ones16), .out_valid(ov16));
  num_ones_unit #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(vs),
    .A(a1), .ones(ones1), .out_valid(ov1));
  num_ones_unit #(.WIDTH(5)) u5 (
    .clk(clk), .reset(reset), .in_valid(vs),
    .A(a5), .ones(ones5), .out_valid(ov5));
  num_ones_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(vs),
    .A(a32), .ones(ones32), .out_valid(ov32));

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] a;
    logic [4:0]  exp_ones;
    logic        exp_v;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain sum of the word's bits.
  function automatic int ref_count(input logic [63:0] w,
                                   input int width);
    int c = 0;
    for (int i = 0; i < width; i++) c += int'(w[i]);
    return c;
  endfunction

  vec_t tbl [$];
  int e1, e5, e32;
  logic [63:0] r;

  initial begin
    tbl = '{
      '{1'b1, 1'b1, 16'hFFFF, 5'd0,  1'b0},
      '{1'b1, 1'b1, 16'hFFFF, 5'd0,  1'b0},
      '{1'b0, 1'b1, 16'hFFFF, 5'd16, 1'b1},
      '{1'b0, 1'b1, 16'hF56F, 5'd12, 1'b1},
      '{1'b0, 1'b1, 16'h3FFF, 5'd14, 1'b1},
      '{1'b0, 1'b1, 16'h0001, 5'd1,  1'b1},
      '{1'b0, 1'b1, 16'hF10F, 5'd9,  1'b1},
      '{1'b0, 1'b1, 16'h7822, 5'd6,  1'b1},
      '{1'b0, 1'b1, 16'h7ABC, 5'd10, 1'b1},
      '{1'b0, 1'b0, 16'hFFFF, 5'd10, 1'b0},
      '{1'b0, 1'b0, 16'hFFFF, 5'd10, 1'b0},
      '{1'b0, 1'b0, 16'hFFFF, 5'd10, 1'b0},
      '{1'b0, 1'b1, 16'h0000, 5'd0,  1'b1},
      '{1'b0, 1'b1, 16'h8000, 5'd1,  1'b1},
      '{1'b0, 1'b1, 16'hAAAA, 5'd8,  1'b1},
      '{1'b0, 1'b1, 16'h5555, 5'd8,  1'b1},
      '{1'b1, 1'b1, 16'hF56F, 5'd0,  1'b0},
      '{1'b0, 1'b1, 16'h0001, 5'd1,  1'b1},
      '{1'b0, 1'b0, 16'hxxxx, 5'd1,  1'b0}
    };

    reset = 1'b1;
    v16 = 1'b0;
    a16 = '0;
    vs = 1'b0;
    a1 = '0;
    a5 = '0;
    a32 = '0;

    foreach (tbl[k]) begin
      reset = tbl[k].rst;
      v16   = tbl[k].vld;
      a16   = tbl[k].a;
      step();
      chk($sformatf("tbl%0d_ones", k),
          64'(ones16), 64'(tbl[k].exp_ones));
      chk($sformatf("tbl%0d_valid", k),
          64'(ov16), 64'(tbl[k].exp_v));
    end

    // Reset while valid streams, then release mid-stream.
    v16 = 1'b1;
    a16 = 16'h00FF;
    step();
    chk("seq_pre_ones", 64'(ones16), 64'd8);
    reset = 1'b1;
    a16 = 16'hFFFF;
    step();
    chk("seq_rst_ones", 64'(ones16), 64'd0);
    chk("seq_rst_valid", 64'(ov16), 64'd0);
    reset = 1'b0;
    a16 = 16'h0F00;
    step();
    chk("seq_post_ones", 64'(ones16), 64'd4);
    chk("seq_post_valid", 64'(ov16), 64'd1);
    v16 = 1'b0;

    // Sweep units: all reset to zero, held since.
    e1 = 0;
    e5 = 0;
    e32 = 0;
    vs = 1'b1;
    a1 = '1;
    a5 = '1;
    a32 = '1;
    step();
    chk("w1_all_ones", 64'(ones1), 64'd1);
    chk("w5_all_ones", 64'(ones5), 64'd5);
    chk("w32_all_ones", 64'(ones32), 64'd32);
    e1 = 1;
    e5 = 5;
    e32 = 32;

    for (int n = 0; n < 1000; n++) begin
      vs = ($urandom_range(3) != 0);
      r = {$urandom, $urandom};
      a1 = r[0:0];
      a5 = r[5:1];
      a32 = r[63:32];
      if (vs) begin
        e1 = ref_count(64'(a1), 1);
        e5 = ref_count(64'(a5), 5);
        e32 = ref_count(64'(a32), 32);
      end
      step();
      chk("w1_ones", 64'(ones1), 64'(e1));
      chk("w5_ones", 64'(ones5), 64'(e5));
      chk("w32_ones", 64'(ones32), 64'(e32));
      chk("w1_valid", 64'(ov1), 64'(vs));
      chk("w5_valid", 64'(ov5), 64'(vs));
      chk("w32_valid", 64'(ov32), 64'(vs));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
